control_seq_p: RTL

//  Parametrised micro-sequencer for the accumulator CPU: fetches from IM, decodes opcode, drives datapath enables.

---
 rtl/ctrl_pkg.sv | 95 +++++++++
 rtl/ctrl_out_decode.sv | 122 ++++++++++++
 rtl/control_seq_p.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-CPU micro-sequencer: state encoding,
// opcode map, enable-vector bit positions, bus source codes and ALU op codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_START,
    S_FETCH1,
    S_FETCH2,
    S_LDAC1,
    S_LDAC2,
    S_LDIAC1,
    S_LDIAC2,
    S_STAC1,
    S_STAC2,
    S_MVAC,
    S_MVACAR,
    S_MVACR1,
    S_MVACR2,
    S_MVACR3,
    S_MVACR4,
    S_MVRAC1,
    S_MVRAC2,
    S_MVRAC3,
    S_MVRAC4,
    S_ADD,
    S_SUB,
    S_MULT,
    S_LSHIFT,
    S_INAC,
    S_CLAC,
    S_NOP,
    S_JPNZ1,
    S_JMPZ1,
    S_JMP2,
    S_HALT
  } state_t;

  // Opcodes are held 32 bits wide so any OPC_W up to 32 compares cleanly.
  localparam logic [31:0] OP_LDAC   = 32'h03;
  localparam logic [31:0] OP_LDIAC  = 32'h05;
  localparam logic [31:0] OP_STAC   = 32'h08;
  localparam logic [31:0] OP_MVAC   = 32'h09;
  localparam logic [31:0] OP_MVACAR = 32'h0A;
  localparam logic [31:0] OP_MVACR1 = 32'h0B;
  localparam logic [31:0] OP_MVACR2 = 32'h0C;
  localparam logic [31:0] OP_MVACR3 = 32'h0D;
  localparam logic [31:0] OP_MVACR4 = 32'h0E;
  localparam logic [31:0] OP_MVRAC1 = 32'h0F;
  localparam logic [31:0] OP_MVRAC2 = 32'h10;
  localparam logic [31:0] OP_MVRAC3 = 32'h11;
  localparam logic [31:0] OP_MVRAC4 = 32'h12;
  localparam logic [31:0] OP_ADD    = 32'h13;
  localparam logic [31:0] OP_MULT   = 32'h14;
  localparam logic [31:0] OP_LSHIFT = 32'h15;
  localparam logic [31:0] OP_SUB    = 32'h16;
  localparam logic [31:0] OP_INAC   = 32'h17;
  localparam logic [31:0] OP_JPNZ   = 32'h18;
  localparam logic [31:0] OP_JMPZ   = 32'h1A;
  localparam logic [31:0] OP_NOP    = 32'h1C;
  localparam logic [31:0] OP_CLAC   = 32'h1E;
  localparam logic [31:0] OP_END    = 32'h1F;

  // Bit positions inside write_en / inc_en / clr_en.
  localparam int EN_PC  = 1;
  localparam int EN_AR  = 2;
  localparam int EN_IR  = 3;
  localparam int EN_AC  = 4;
  localparam int EN_R   = 5;
  localparam int EN_R4  = 7;
  localparam int EN_R3  = 8;
  localparam int EN_R2  = 9;
  localparam int EN_R1  = 10;
  localparam int EN_DM  = 11;
  localparam int EN_ALU = 12;

  // Bus source selects on read_en.
  localparam logic [3:0] RD_NONE = 4'd0;
  localparam logic [3:0] RD_IR   = 4'd4;
  localparam logic [3:0] RD_AC   = 4'd5;
  localparam logic [3:0] RD_R    = 4'd6;
  localparam logic [3:0] RD_R1   = 4'd7;
  localparam logic [3:0] RD_R2   = 4'd8;
  localparam logic [3:0] RD_R3   = 4'd9;
  localparam logic [3:0] RD_R4   = 4'd10;
  localparam logic [3:0] RD_DM   = 4'd12;
  localparam logic [3:0] RD_IM   = 4'd13;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MULT = 3'd3;
  localparam logic [2:0] ALU_LSH  = 3'd4;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational output decode: current sequencer state (plus mem_rdy for the
// memory-strobed writes) to datapath enables, bus source and ALU op.
module ctrl_out_decode
  import ctrl_pkg::*;
#(
  parameter int EN_W = 16
) (
  input  state_t            state,
  input  logic              mem_rdy,
  output logic [2:0]        alu_op,
  output logic [EN_W-1:0]   write_en,
  output logic [EN_W-1:0]   inc_en,
  output logic [EN_W-1:0]   clr_en,
  output logic [3:0]        read_en,
  output logic              end_process
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    alu_op      = ALU_NONE;
    write_en    = '0;
    inc_en      = '0;
    clr_en      = '0;
    read_en     = RD_NONE;
    end_process = 1'b0;

    unique case (state)
      S_START: begin
        clr_en[EN_PC] = 1'b1;
        clr_en[EN_AR] = 1'b1;
      end
      S_FETCH1: begin
        read_en         = RD_IM;
        write_en[EN_IR] = mem_rdy;
      end
      S_FETCH2: inc_en[EN_PC] = 1'b1;
      S_LDAC1: begin
        read_en         = RD_AC;
        write_en[EN_AR] = 1'b1;
      end
      S_LDIAC1: begin
        read_en         = RD_IR;
        write_en[EN_AR] = 1'b1;
      end
      S_LDAC2, S_LDIAC2: begin
        read_en         = RD_DM;
        write_en[EN_AC] = mem_rdy;
      end
      S_STAC1: read_en = RD_AC;
      S_STAC2: begin
        read_en         = RD_AC;
        write_en[EN_DM] = mem_rdy;
      end
      S_MVAC: begin
        read_en        = RD_AC;
        write_en[EN_R] = 1'b1;
      end
      S_MVACAR: begin
        read_en         = RD_AC;
        write_en[EN_AR] = 1'b1;
      end
      S_MVACR1: begin
        read_en         = RD_AC;
        write_en[EN_R1] = 1'b1;
      end
      S_MVACR2: begin
        read_en         = RD_AC;
        write_en[EN_R2] = 1'b1;
      end
      S_MVACR3: begin
        read_en         = RD_AC;
        write_en[EN_R3] = 1'b1;
      end
      S_MVACR4: begin
        read_en         = RD_AC;
        write_en[EN_R4] = 1'b1;
      end
      S_MVRAC1: begin
        read_en         = RD_R1;
        write_en[EN_AC] = 1'b1;
      end
      S_MVRAC2: begin
        read_en         = RD_R2;
        write_en[EN_AC] = 1'b1;
      end
      S_MVRAC3: begin
        read_en         = RD_R3;
        write_en[EN_AC] = 1'b1;
      end
      S_MVRAC4: begin
        read_en         = RD_R4;
        write_en[EN_AC] = 1'b1;
      end
      S_ADD: begin
        alu_op           = ALU_ADD;
        write_en[EN_ALU] = 1'b1;
      end
      S_SUB: begin
        alu_op           = ALU_SUB;
        write_en[EN_ALU] = 1'b1;
      end
      S_MULT: begin
        alu_op           = ALU_MULT;
        write_en[EN_ALU] = 1'b1;
      end
      S_LSHIFT: begin
        alu_op           = ALU_LSH;
        write_en[EN_ALU] = 1'b1;
      end
      S_INAC: inc_en[EN_AC] = 1'b1;
      S_CLAC: clr_en[EN_AC] = 1'b1;
      S_JMP2: begin
        read_en         = RD_IR;
        write_en[EN_PC] = 1'b1;
      end
      S_HALT: end_process = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_seq_p.sv
// Micro-sequencer for the accumulator CPU: fetch/decode state machine with
// memory wait states, illegal-opcode trap and retired-instruction counter.
module control_seq_p
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 6,
  parameter int NUM_GPR = 4,
  parameter int EN_W    = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] z,
  input  logic [OPC_W-1:0]  instruction,
  output logic [2:0]        alu_op,
  output logic [EN_W-1:0]   write_en,
  output logic [EN_W-1:0]   inc_en,
  output logic [EN_W-1:0]   clr_en,
  output logic [3:0]        read_en,
  output logic              end_process,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t      state, state_d;
  logic        zero;
  logic [31:0] opc_ext;
  logic        launch;
  logic        retire;
  logic        set_illegal;

  assign zero    = ~|z;
  assign opc_ext = 32'(instruction);

  always_comb begin
    int  gpr_n;
    logic legal;

    state_d     = state;
    launch      = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    gpr_n       = 0;
    legal       = 1'b1;

    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_START;
          launch  = 1'b1;
        end
      end
      S_START:  state_d = S_FETCH1;
      S_FETCH1: if (mem_rdy) state_d = S_FETCH2;
      S_FETCH2: begin
        unique case (opc_ext)
          OP_LDAC:   state_d = S_LDAC1;
          OP_LDIAC:  state_d = S_LDIAC1;
          OP_STAC:   state_d = S_STAC1;
          OP_MVAC:   state_d = S_MVAC;
          OP_MVACAR: state_d = S_MVACAR;
          OP_MVACR1: begin state_d = S_MVACR1; gpr_n = 1; end
          OP_MVACR2: begin state_d = S_MVACR2; gpr_n = 2; end
          OP_MVACR3: begin state_d = S_MVACR3; gpr_n = 3; end
          OP_MVACR4: begin state_d = S_MVACR4; gpr_n = 4; end
          OP_MVRAC1: begin state_d = S_MVRAC1; gpr_n = 1; end
          OP_MVRAC2: begin state_d = S_MVRAC2; gpr_n = 2; end
          OP_MVRAC3: begin state_d = S_MVRAC3; gpr_n = 3; end
          OP_MVRAC4: begin state_d = S_MVRAC4; gpr_n = 4; end
          OP_ADD:    state_d = S_ADD;
          OP_MULT:   state_d = S_MULT;
          OP_LSHIFT: state_d = S_LSHIFT;
          OP_SUB:    state_d = S_SUB;
          OP_INAC:   state_d = S_INAC;
          OP_JPNZ:   state_d = S_JPNZ1;
          OP_JMPZ:   state_d = S_JMPZ1;
          OP_NOP:    state_d = S_NOP;
          OP_CLAC:   state_d = S_CLAC;
          OP_END: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default:   legal = 1'b0;
        endcase
        // Register moves naming a GPR beyond the configured count trap too.
        if (gpr_n > NUM_GPR) legal = 1'b0;
        if (!legal) begin
          state_d     = S_HALT;
          retire      = 1'b0;
          set_illegal = 1'b1;
        end
      end
      S_LDAC1:  state_d = S_LDAC2;
      S_LDIAC1: state_d = S_LDIAC2;
      S_STAC1:  state_d = S_STAC2;
      S_LDAC2, S_LDIAC2, S_STAC2: begin
        if (mem_rdy) begin
          state_d = S_FETCH1;
          retire  = 1'b1;
        end
      end
      // Jump condition is taken from z only in this first jump cycle.
      S_JPNZ1: begin
        if (!zero) state_d = S_JMP2;
        else begin
          state_d = S_FETCH1;
          retire  = 1'b1;
        end
      end
      S_JMPZ1: begin
        if (zero) state_d = S_JMP2;
        else begin
          state_d = S_FETCH1;
          retire  = 1'b1;
        end
      end
      S_JMP2, S_MVAC, S_MVACAR,
      S_MVACR1, S_MVACR2, S_MVACR3, S_MVACR4,
      S_MVRAC1, S_MVRAC2, S_MVRAC3, S_MVRAC4,
      S_ADD, S_SUB, S_MULT, S_LSHIFT,
      S_INAC, S_CLAC, S_NOP: begin
        state_d = S_FETCH1;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_d;
      if (launch) begin
        instr_cnt <= '0;
        illegal   <= 1'b0;
      end else begin
        if (retire)      instr_cnt <= instr_cnt + CNT_W'(1);
        if (set_illegal) illegal   <= 1'b1;
      end
    end
  end

  ctrl_out_decode #(
    .EN_W(EN_W)
  ) u_out_decode (
    .state       (state),
    .mem_rdy     (mem_rdy),
    .alu_op      (alu_op),
    .write_en    (write_en),
    .inc_en      (inc_en),
    .clr_en      (clr_en),
    .read_en     (read_en),
    .end_process (end_process)
  );

endmodule
